// File: rtl/xadc_channel_classifier.sv
// xadc_channel_classifier: DRP scan sequencer with block averaging and hysteresis argmax.
// Ports: S_AXI_ACLK / S_AXI_ARESETN clock and asynchronous active-low reset;
//   enable, clear, EOS run control; DADDR, DEN, DWE, DI, DRDY, DO DRP master;
//   measured, network_output, result_valid, scan_count published results;
//   timeout_err sticky DRP timeout, busy scan in progress.
module xadc_channel_classifier #(
  parameter int          NUM_CHANNELS = 4,
  parameter logic [6:0]  BASE_DADDR   = 7'h10,
  parameter int          AVG_LOG2     = 2,
  parameter logic [11:0] HYST_MARGIN  = 12'd32,
  parameter int          DRP_TIMEOUT  = 64,
  parameter int          IDX_W        = 2
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       EOS,
  input  logic                       DRDY,
  input  logic [15:0]                DO,
  output logic [6:0]                 DADDR,
  output logic                       DEN,
  output logic                       DWE,
  output logic [15:0]                DI,
  output logic [12*NUM_CHANNELS-1:0] measured,
  output logic [IDX_W-1:0]           network_output,
  output logic                       result_valid,
  output logic [15:0]                scan_count,
  output logic                       timeout_err,
  output logic                       busy
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int WW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int TW = $clog2(DRP_TIMEOUT + 1);
  localparam logic [WW-1:0]    WIN_LAST = WW'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(DRP_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, CMP, PUB} state_t;
  state_t           state_q;
  logic [IDX_W-1:0] ch_q, best_idx_q, cand;
  logic [11:0]      best_val_q, sample_q, cand_val;
  logic [WW-1:0]    win_q;
  logic [TW-1:0]    tmo_q;
  logic             first_q, cand_take, take;
  logic [AW-1:0]    acc_q [NUM_CHANNELS];
  logic [11:0]      meas_q [NUM_CHANNELS];
  logic [11:0]      avg [NUM_CHANNELS];
  logic             unused_do;
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign avg[i] = acc_q[i][AW-1:AVG_LOG2];
    assign measured[12*i +: 12] = meas_q[i];
  end
  assign unused_do = ^DO[3:0];
  assign DWE = 1'b0;
  assign DI = 16'h0000;
  assign busy = state_q != IDLE;
  // ch_q doubles as the compare index during CMP; channel 0 seeds the running best.
  assign cand_take = ch_q == '0 || avg[ch_q] > best_val_q;
  assign cand = cand_take ? ch_q : best_idx_q;
  assign cand_val = cand_take ? avg[ch_q] : best_val_q;
  assign take = first_q || cand == network_output ||
                {1'b0, cand_val} > {1'b0, avg[network_output]} + 13'(HYST_MARGIN);
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      ch_q <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      sample_q <= '0;
      win_q <= '0;
      tmo_q <= '0;
      first_q <= 1'b1;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i] <= '0;
        meas_q[i] <= '0;
      end
      DADDR <= '0;
      DEN <= 1'b0;
      network_output <= '0;
      result_valid <= 1'b0;
      scan_count <= '0;
      timeout_err <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      win_q <= '0;
      first_q <= 1'b1;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i] <= '0;
        meas_q[i] <= '0;
      end
      DEN <= 1'b0;
      network_output <= '0;
      result_valid <= 1'b0;
      scan_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      DEN <= 1'b0;
      result_valid <= 1'b0;
      case (state_q)
        IDLE: if (EOS && enable) begin
          state_q <= REQ;
          ch_q <= '0;
          DEN <= 1'b1;
          DADDR <= BASE_DADDR;
        end
        REQ: begin
          state_q <= WAIT;
          tmo_q <= '0;
        end
        WAIT: if (DRDY) begin
          sample_q <= DO[15:4];
          state_q <= ACC;
        end else if (tmo_q == TMO_LAST) begin
          // No answer: reuse the last published value so the average stays sane.
          timeout_err <= 1'b1;
          sample_q <= meas_q[ch_q];
          state_q <= ACC;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        ACC: begin
          acc_q[ch_q] <= acc_q[ch_q] + AW'(sample_q);
          if (ch_q != CH_LAST) begin
            ch_q <= ch_q + 1'b1;
            DEN <= 1'b1;
            DADDR <= BASE_DADDR + 7'(ch_q + 1'b1);
            state_q <= REQ;
          end else if (win_q != WIN_LAST) begin
            win_q <= win_q + 1'b1;
            state_q <= IDLE;
          end else begin
            ch_q <= '0;
            state_q <= CMP;
          end
        end
        CMP: begin
          best_idx_q <= cand;
          best_val_q <= cand_val;
          if (ch_q == CH_LAST) begin
            for (int i = 0; i < NUM_CHANNELS; i++) meas_q[i] <= avg[i];
            network_output <= take ? cand : network_output;
            first_q <= 1'b0;
            result_valid <= 1'b1;
            scan_count <= scan_count + 1'b1;
            state_q <= PUB;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        PUB: begin
          for (int i = 0; i < NUM_CHANNELS; i++) acc_q[i] <= '0;
          win_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
